// File: rtl/enable_gen_pkg.sv
// enable_gen_pkg
// Shared types and default widths for the enable-pulse generator.
//   enable_gen_state_t : controller state encoding (IDLE, RUN)
//   DIV_WIDTH_DEF      : default width of the pulse period value
//   BURST_WIDTH_DEF    : default width of the burst length / pulse count
package enable_gen_pkg;

    localparam int DIV_WIDTH_DEF   = 8;
    localparam int BURST_WIDTH_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } enable_gen_state_t;

endpackage : enable_gen_pkg

// File: rtl/tick_divider.sv
// tick_divider
// Prescaler for the enable generator. Counts p from 0 up to div_q-1 while
// run is high and flags the terminal count on tick.
// Ports:
//   clock   in   rising-edge clock
//   reset_n in   asynchronous active-low reset
//   clear   in   synchronous clear of p (takes priority over run)
//   run     in   advance p this cycle
//   div_q   in   latched period, always >= 1
//   tick    out  high when p == div_q-1
module tick_divider #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] div_q,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] p_q;
    logic [DIV_WIDTH-1:0] p_d;

    // div_q is never 0 here, so div_q-1 cannot underflow.
    assign tick = (p_q == (div_q - 1'b1));

    always_comb begin
        p_d = p_q;
        if (clear) begin
            p_d = '0;
        end else if (run) begin
            p_d = tick ? '0 : (p_q + 1'b1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

endmodule : tick_divider

// File: rtl/enable_gen.sv
// enable_gen
// Programmable enable-pulse generator feeding the 4-bit counter's enable.
// On start it emits single-cycle enable pulses every divisor clocks, either
// for burst_len pulses or continuously (burst_len = 0) until stop.
// Ports:
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   start       in   starts a run when idle (ignored while running)
//   stop        in   aborts a run; wins over start when idle
//   divisor     in   pulse period in clocks, 0 treated as 1
//   burst_len   in   number of pulses, 0 = continuous
//   enable      out  registered single-cycle pulse
//   busy        out  high while running
//   done        out  single-cycle pulse on normal burst completion
//   pulse_count out  pulses issued in the current or last run
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; divisor/burst_len are sampled on leaving
// RUN   | prescaler running, pulses issued on each tick until burst end
//       | or stop
module enable_gen
    import enable_gen_pkg::*;
#(
    parameter int DIV_WIDTH   = DIV_WIDTH_DEF,
    parameter int BURST_WIDTH = BURST_WIDTH_DEF
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [DIV_WIDTH-1:0]   divisor,
    input  logic [BURST_WIDTH-1:0] burst_len,
    output logic                   enable,
    output logic                   busy,
    output logic                   done,
    output logic [BURST_WIDTH-1:0] pulse_count
);

    enable_gen_state_t      state_q, state_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [BURST_WIDTH-1:0] burst_q, burst_d;
    logic [BURST_WIDTH-1:0] pulse_count_q, pulse_count_d;
    logic                   enable_q, enable_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    logic                   div_clear;
    logic                   div_run;
    logic                   tick;
    logic [BURST_WIDTH-1:0] pulse_count_inc;

    tick_divider #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick_divider (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (div_clear),
        .run     (div_run),
        .div_q   (div_q),
        .tick    (tick)
    );

    assign pulse_count_inc = pulse_count_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        burst_d       = burst_q;
        pulse_count_d = pulse_count_q;
        enable_d      = 1'b0;
        done_d        = 1'b0;
        div_clear     = 1'b0;
        div_run       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d       = RUN;
                    div_d         = (divisor == '0) ? DIV_WIDTH'(1) : divisor;
                    burst_d       = burst_len;
                    pulse_count_d = '0;
                    div_clear     = 1'b1;
                end
            end
            RUN: begin
                // stop has priority and swallows a pulse due on this edge.
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    div_run = 1'b1;
                    if (tick) begin
                        enable_d      = 1'b1;
                        pulse_count_d = pulse_count_inc;
                        if ((burst_q != '0) && (pulse_count_inc == burst_q)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            div_q         <= DIV_WIDTH'(1);
            burst_q       <= '0;
            pulse_count_q <= '0;
            enable_q      <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            burst_q       <= burst_d;
            pulse_count_q <= pulse_count_d;
            enable_q      <= enable_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    assign enable      = enable_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pulse_count = pulse_count_q;

endmodule : enable_gen

// File: tb/tb_enable_gen.sv
module tb_enable_gen;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic       stop;
    logic [7:0] divisor;
    logic [3:0] burst_len;
    logic       enable;
    logic       busy;
    logic       done;
    logic [3:0] pulse_count;

    int errors;
    int checks;

    enable_gen dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .divisor     (divisor),
        .burst_len   (burst_len),
        .enable      (enable),
        .busy        (busy),
        .done        (done),
        .pulse_count (pulse_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge and settle just after it; inputs driven here are
    // sampled on the following edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive a start for one edge; returns just after E0.
    task automatic launch(input logic [7:0] div, input logic [3:0] blen);
        divisor   = div;
        burst_len = blen;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0; stop = 1'b0; divisor = 8'd0; burst_len = 4'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({enable, busy, done, pulse_count} !== 7'd0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d: got en=%b busy=%b done=%b cnt=%0d, expected all 0",
                         i, enable, busy, done, pulse_count);
            end
        end
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({enable, busy, done, pulse_count} !== 7'd0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d: got en=%b busy=%b done=%b cnt=%0d, expected all 0",
                         i, enable, busy, done, pulse_count);
            end
        end
    endtask

    task automatic test_burst();
        launch(8'd3, 4'd4);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL burst_busy_e0: got %b expected 1", busy);
        end
        // Changes after start must not affect the run.
        divisor = 8'd1; burst_len = 4'd9;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (enable !== ((k % 3) == 0)) begin
                errors++;
                $display("FAIL burst_enable k=%0d: got %b expected %b", k, enable, (k % 3) == 0);
            end
            checks++;
            if (done !== (k == 12) || busy !== (k != 12)) begin
                errors++;
                $display("FAIL burst_done_busy k=%0d: got done=%b busy=%b expected done=%b busy=%b",
                         k, done, busy, k == 12, k != 12);
            end
            checks++;
            if (pulse_count !== 4'(k / 3)) begin
                errors++;
                $display("FAIL burst_count k=%0d: got %0d expected %0d", k, pulse_count, k / 3);
            end
        end
        for (int k = 13; k <= 15; k++) begin
            step();
            checks++;
            if (enable !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || pulse_count !== 4'd4) begin
                errors++;
                $display("FAIL burst_after k=%0d: got en=%b done=%b busy=%b cnt=%0d expected 0 0 0 4",
                         k, enable, done, busy, pulse_count);
            end
        end
    endtask

    task automatic test_stop();
        launch(8'd2, 4'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (enable !== ((k % 2) == 0) || busy !== 1'b1) begin
                errors++;
                $display("FAIL stop_run k=%0d: got en=%b busy=%b expected en=%b busy=1",
                         k, enable, busy, (k % 2) == 0);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pulse_count !== 4'd2) begin
            errors++;
            $display("FAIL stop_abort: got en=%b busy=%b done=%b cnt=%0d expected 0 0 0 2",
                     enable, busy, done, pulse_count);
        end
        for (int k = 7; k <= 10; k++) begin
            step();
            checks++;
            if (enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL stop_after k=%0d: got en=%b busy=%b done=%b expected 0 0 0",
                         k, enable, busy, done);
            end
        end
    endtask

    task automatic test_div_zero();
        launch(8'd0, 4'd3);
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (enable !== (k <= 3) || done !== (k == 3) || busy !== (k < 3)) begin
                errors++;
                $display("FAIL div0 k=%0d: got en=%b done=%b busy=%b expected %b %b %b",
                         k, enable, done, busy, k <= 3, k == 3, k < 3);
            end
        end
        checks++;
        if (pulse_count !== 4'd3) begin
            errors++;
            $display("FAIL div0_count: got %0d expected 3", pulse_count);
        end
    endtask

    task automatic test_start_stop_idle();
        divisor = 8'd1; burst_len = 4'd0;
        start = 1'b1; stop = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (busy !== 1'b0 || enable !== 1'b0 || pulse_count !== 4'd3) begin
                errors++;
                $display("FAIL start_stop_idle k=%0d: got busy=%b en=%b cnt=%0d expected 0 0 3",
                         k, busy, enable, pulse_count);
            end
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_wrap();
        launch(8'd1, 4'd0);
        for (int k = 1; k <= 17; k++) begin
            step();
            checks++;
            if (enable !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || pulse_count !== 4'(k % 16)) begin
                errors++;
                $display("FAIL wrap k=%0d: got en=%b busy=%b done=%b cnt=%0d expected 1 1 0 %0d",
                         k, enable, busy, done, pulse_count, k % 16);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || enable !== 1'b0 || pulse_count !== 4'd1) begin
            errors++;
            $display("FAIL wrap_stop: got busy=%b en=%b cnt=%0d expected 0 0 1", busy, enable, pulse_count);
        end
    endtask

    task automatic test_async_reset();
        launch(8'd4, 4'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (enable !== (k == 4)) begin
                errors++;
                $display("FAIL arst_run k=%0d: got en=%b expected %b", k, enable, k == 4);
            end
        end
        start = 1'b1;
        divisor = 8'd1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || enable !== 1'b0 || pulse_count !== 4'd1) begin
            errors++;
            $display("FAIL arst_start_ignored: got busy=%b en=%b cnt=%0d expected 1 0 1",
                     busy, enable, pulse_count);
        end
        step();
        step();
        checks++;
        if (enable !== 1'b1 || pulse_count !== 4'd2) begin
            errors++;
            $display("FAIL arst_pulse8: got en=%b cnt=%0d expected 1 2", enable, pulse_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (enable !== 1'b0 || busy !== 1'b0 || pulse_count !== 4'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate: got en=%b busy=%b done=%b cnt=%0d expected all 0",
                     enable, busy, done, pulse_count);
        end
        step();
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (enable !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL arst_after k=%0d: got en=%b busy=%b expected 0 0", k, enable, busy);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset_n = 1'b0;
        start = 1'b0; stop = 1'b0; divisor = 8'd0; burst_len = 4'd0;
        test_reset();
        test_burst();
        test_stop();
        test_div_zero();
        test_start_stop_idle();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_enable_gen

// File: doc/enable_gen.md
# enable_gen

Programmable enable-pulse generator that drives the `enable` input of the 4-bit free-running counter stage. On a start command it issues single-cycle enable pulses every `divisor` clocks, either for a fixed burst or continuously until stopped. It sits directly upstream of the counter and shares its clock domain.

## Interface
- `DIV_WIDTH`, default 8: width of the period value.
- `BURST_WIDTH`, default 4: width of the burst length and the pulse count.

Ports:
- `clock`  in  1: rising-edge clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: level-sampled; starts a run when the block is idle.
- `stop`  in  1: level-sampled; aborts a run.
- `divisor`  in  DIV_WIDTH: pulse period in clocks; 0 is treated as 1.
- `burst_len`  in  BURST_WIDTH: number of pulses; 0 means continuous.
- `enable`  out  1: registered single-cycle pulse; connects to the counter `enable`.
- `busy`  out  1: high while in RUN.
- `done`  out  1: single-cycle pulse when a burst completes normally.
- `pulse_count`  out  BURST_WIDTH: number of pulses issued in the current or last run.

## Operation
- The FSM has two states: IDLE and RUN.
- IDLE to RUN: `start`=1 and `stop`=0 at a clock edge.
  - Latch `div_q` = (`divisor`==0 ? 1 : `divisor`) and `burst_q` = `burst_len`.
  - Clear the prescaler `p` and `pulse_count` to 0.
- In RUN, on each edge:
  - If `p` == `div_q`-1: `p`<=0, `enable`<=1, `pulse_count`<=`pulse_count`+1.
  - Otherwise: `p`<=`p`+1, `enable`<=0.
- Burst termination: if `burst_q`!=0 and a pulse is issued with `pulse_count`+1 == `burst_q`, the FSM goes to IDLE and `done`<=1 on the same edge as that final `enable`.
- `stop`=1 in RUN: go to IDLE on that edge with `enable`<=0 and `done`<=0. `stop` suppresses any pulse due on the same edge.
- `start` while in RUN is ignored. Input changes to `divisor` or `burst_len` during a run are ignored because the values are latched at start.
- `start` and `stop` together in IDLE: stay in IDLE (stop wins).
- Continuous mode (`burst_len`=0): `pulse_count` wraps modulo 2^BURST_WIDTH and `done` never asserts.
- `pulse_count` holds its final value in IDLE until the next start.
- With `div_q`=1, `enable` is high on every cycle of RUN after the first edge.

## Timing
- Reset value of every output is 0: `enable`, `busy`, `done`, `pulse_count`. The FSM resets to IDLE and `p` to 0. Reset takes effect immediately, without waiting for a clock edge.
- Reset mid-run aborts the run. No further `enable` is issued until a new start after reset release.
- Let edge E0 be the edge where `start` is accepted.
  - `busy` is high after E0.
  - The first `enable` is high after edge E0+`div_q`; subsequent pulses follow every `div_q` edges.
- Last burst pulse: `enable`=1 and `done`=1 in the same cycle, and `busy` goes 0 in that same cycle.
- After `stop` is sampled: `busy`=0 and `enable`=0 from the next cycle.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package `enable_gen_pkg`:
  - state typedef `enable_gen_state_t` {IDLE, RUN};
  - default width constants `DIV_WIDTH_DEF`=8 and `BURST_WIDTH_DEF`=4.
- Optional sub-module `tick_divider`: holds `p`, takes `clear`, `run` and `div_q`, and outputs a `tick` (`p`==`div_q`-1). The top level keeps the FSM, burst counter and output registers.

## Test plan
- Reset then idle: hold `reset_n`=0 for 3 cycles and release with `start`=0 → all outputs stay 0 for 20 cycles.
- Fixed burst: `divisor`=3, `burst_len`=4, start at E0 → `enable` high after E0+3, +6, +9 and +12 only; `done`=1 and `busy`=0 after E0+12; `pulse_count`=4.
- Stop abort: `divisor`=2, `burst_len`=0, `stop` asserted at E0+5 (when a pulse would be due at E0+6) → pulses after E0+2 and E0+4 only; `done` never asserts; `pulse_count`=2.
- Edge values:
  - `divisor`=0 with `burst_len`=3 → `enable` high after E0+1, +2 and +3; `done` after E0+3.
  - `start` and `stop` together in IDLE → no transition.
- Continuous wrap: `divisor`=1, `burst_len`=0, run 17 cycles → `pulse_count` shows 15, 0, 1 across the wrap; `enable` high continuously.
- Async reset mid-run: pull `reset_n` low between edges during a `divisor`=4 run → `enable`, `busy` and `pulse_count` go to 0 immediately; `start` in the middle of a run is verified ignored before the reset.
